// File: rtl/ghost_ram_ctrl.sv
// Write-side controller for the ghost sprite RAM: round-robin arbitration between
// the host bus (A) and the animation engine (B), plus a whole-RAM fill engine.
module ghost_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_gnt,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_gnt,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   color_q, color_d;
  logic                    last_b_q, last_b_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      last_b_q   <= 1'b1;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      last_b_q   <= last_b_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    last_b_d   = last_b_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;

    // Requesters are locked out only while fill writes are being issued.
    if (state_q != S_FILL) begin
      if (a_req && (!b_req || last_b_q)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end

    if (a_gnt) begin
      ram_we_d   = 1'b1;
      ram_addr_d = a_addr;
      ram_din_d  = a_data;
      last_b_d   = 1'b0;
    end else if (b_gnt) begin
      ram_we_d   = 1'b1;
      ram_addr_d = b_addr;
      ram_din_d  = b_data;
      last_b_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          state_d = S_FILL;
          cnt_d   = '0;
          color_d = fill_color;
        end
      end
      S_FILL: begin
        ram_we_d   = 1'b1;
        ram_addr_d = cnt_q;
        ram_din_d  = color_q;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fill_busy  = (state_q == S_FILL);
  assign fill_done  = (state_q == S_DONE);
  assign ram_we     = ram_we_q;
  assign ram_addr_w = ram_addr_q;
  assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_ghost_ram_ctrl.sv
// Bench for ghost_ram_ctrl: scenario tasks checked against a cycle-level reference
// model built from the arbitration and fill rules (fill writes remaining, last winner).
module tb_ghost_ram_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int VW    = AW + DW + 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0, fill_start = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0, fill_color = '0;
  logic          a_gnt, b_gnt, fill_busy, fill_done, ram_we;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_din;
  logic [VW-1:0] obs;

  int checks = 0;
  int failures = 0;

  ghost_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  assign obs = {a_gnt, b_gnt, ram_we, ram_addr_w, ram_din, fill_busy, fill_done};

  // Reference model: fill writes still owed, next fill address, who won last,
  // and the write the RAM port should be presenting this cycle.
  int            m_fill_left = 0;
  int            m_fill_addr = 0;
  logic [DW-1:0] m_col = '0;
  logic          m_done = 1'b0;
  logic          m_last_a = 1'b0;
  logic          e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din = '0;

  function automatic logic want_a();
    if (m_fill_left > 0) return 1'b0;
    if (a_req && b_req) return !m_last_a;
    return a_req;
  endfunction

  function automatic logic want_b();
    if (m_fill_left > 0) return 1'b0;
    if (a_req && b_req) return m_last_a;
    return b_req;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {want_a(), want_b(), e_we, e_addr, e_din, (m_fill_left > 0), m_done};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fill_left <= 0;
      m_fill_addr <= 0;
      m_col       <= '0;
      m_done      <= 1'b0;
      m_last_a    <= 1'b0;
      e_we        <= 1'b0;
      e_addr      <= '0;
      e_din       <= '0;
    end else if (m_fill_left > 0) begin
      e_we        <= 1'b1;
      e_addr      <= AW'(m_fill_addr);
      e_din       <= m_col;
      m_fill_addr <= m_fill_addr + 1;
      m_fill_left <= m_fill_left - 1;
      m_done      <= (m_fill_left == 1);
    end else begin
      m_done <= 1'b0;
      e_we   <= want_a() || want_b();
      if (want_a()) begin
        e_addr   <= a_addr;
        e_din    <= a_data;
        m_last_a <= 1'b1;
      end else if (want_b()) begin
        e_addr   <= b_addr;
        e_din    <= b_data;
        m_last_a <= 1'b0;
      end
      if (fill_start && !m_done) begin
        m_fill_left <= DEPTH;
        m_fill_addr <= 0;
        m_col       <= fill_color;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = 1'b0; b_req = 1'b0; fill_start = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; fill_color = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, {VW{1'b0}});
    end
    a_req = 1'b1; b_req = 1'b1; a_addr = AW'(10'h0AA); b_addr = AW'(10'h0BB);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL first_contest gnt(a,b) got=%b exp=10", {a_gnt, b_gnt});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, ram_we, ram_addr_w} !== {2'b01, 1'b1, AW'(10'h0AA)}) begin
      failures++;
      $display("FAIL second_contest got=%h exp=%h", {a_gnt, b_gnt, ram_we, ram_addr_w},
               {2'b01, 1'b1, AW'(10'h0AA)});
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    apply_reset();
    a_req = 1'b1; a_addr = AW'(10'h005); a_data = 2'b11;
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL single_gnt got=%b exp=10", {a_gnt, b_gnt});
    end
    tick();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr_w, ram_din} !== {1'b1, AW'(10'h005), 2'b11}) begin
      failures++;
      $display("FAIL single_write got=%h exp=%h", {ram_we, ram_addr_w, ram_din},
               {1'b1, AW'(10'h005), 2'b11});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr_w, ram_din} !== {1'b0, AW'(10'h005), 2'b11}) begin
      failures++;
      $display("FAIL idle_hold got=%h exp=%h", {ram_we, ram_addr_w, ram_din},
               {1'b0, AW'(10'h005), 2'b11});
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] last_addr;
    last_addr = '0;
    apply_reset();
    a_req = 1'b1; b_req = 1'b1;
    a_addr = AW'(10'h010); b_addr = AW'(10'h020); a_data = 2'b01; b_data = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL rr_gnt i=%0d got=%b%b exp=%b%b", i, a_gnt, b_gnt, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        checks++;
        if (ram_we !== 1'b1 || ram_addr_w !== last_addr) begin
          failures++;
          $display("FAIL rr_write i=%0d got we=%b addr=%h exp we=1 addr=%h", i, ram_we, ram_addr_w, last_addr);
        end
      end
      last_addr = (i % 2 == 0) ? a_addr : b_addr;
      tick();
      if (i % 2 == 0) a_addr = a_addr + AW'(1);
      else b_addr = b_addr + AW'(1);
      if (i == 3) begin a_req = 1'b0; b_req = 1'b0; end
    end
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr_w !== last_addr) begin
      failures++;
      $display("FAIL rr_last_write got we=%b addr=%h exp we=1 addr=%h", ram_we, ram_addr_w, last_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL rr_end_we got=%b exp=0", ram_we);
    end
  endtask

  task automatic test_random();
    logic ga, gb;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      ga = a_gnt;
      gb = b_gnt;
      tick();
      fill_start = ($urandom_range(0, 199) == 0);
      fill_color = DW'($urandom);
      if (!a_req || ga) begin
        a_req = ($urandom_range(0, 2) != 0); a_addr = AW'($urandom); a_data = DW'($urandom);
      end
      if (!b_req || gb) begin
        b_req = ($urandom_range(0, 2) != 0); b_addr = AW'($urandom); b_data = DW'($urandom);
      end
    end
    clear_inputs();
  endtask

  task automatic test_fill();
    int busy_cnt, done_cnt, gnt_in_fill, idx, bad;
    logic prev_busy;
    busy_cnt = 0; done_cnt = 0; gnt_in_fill = 0; idx = 0; bad = 0; prev_busy = 1'b0;
    apply_reset();
    a_req = 1'b1; a_addr = AW'($urandom); a_data = DW'($urandom);
    fill_start = 1'b1; fill_color = 2'b01;
    for (int c = 0; c < 1040; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL fill cyc=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      if (fill_busy && a_gnt) gnt_in_fill++;
      if (fill_busy) busy_cnt++;
      if (fill_done) begin
        done_cnt++;
        checks++;
        if (a_gnt !== 1'b1) begin
          failures++;
          $display("FAIL done_gnt cyc=%0d got=%b exp=1", c, a_gnt);
        end
      end
      if (prev_busy) begin
        if (!(ram_we === 1'b1 && ram_addr_w === AW'(idx) && ram_din === 2'b01)) bad++;
        idx++;
      end
      prev_busy = fill_busy;
      tick();
      fill_start = (c == 299);
      fill_color = 2'b10;
    end
    checks++;
    if (busy_cnt != DEPTH || done_cnt != 1 || gnt_in_fill != 0) begin
      failures++;
      $display("FAIL fill_counts got busy=%0d done=%0d gnt=%0d exp busy=%0d done=1 gnt=0",
               busy_cnt, done_cnt, gnt_in_fill, DEPTH);
    end
    checks++;
    if (idx != DEPTH || bad != 0) begin
      failures++;
      $display("FAIL fill_writes got writes=%0d bad=%0d exp writes=%0d bad=0", idx, bad, DEPTH);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_fill();
    int done_cnt;
    done_cnt = 0;
    apply_reset();
    fill_start = 1'b1; fill_color = 2'b10;
    tick();
    fill_start = 1'b0;
    repeat (512) tick();
    @(negedge clk);
    checks++;
    if ({fill_busy, ram_we, ram_addr_w} !== {2'b11, AW'(10'h1FF)}) begin
      failures++;
      $display("FAIL pre_abort got=%h exp=%h", {fill_busy, ram_we, ram_addr_w}, {2'b11, AW'(10'h1FF)});
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, fill_busy, fill_done, ram_addr_w, ram_din} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got=%h exp=0", {ram_we, fill_busy, fill_done, ram_addr_w, ram_din});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fill_done) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d exp=0", done_cnt);
    end
    fill_start = 1'b1; fill_color = 2'b11;
    tick();
    fill_start = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({fill_busy, ram_we, ram_addr_w, ram_din} !== {2'b11, AW'(0), 2'b11}) begin
      failures++;
      $display("FAIL restart got=%h exp=%h", {fill_busy, ram_we, ram_addr_w, ram_din}, {2'b11, AW'(0), 2'b11});
    end
    for (int c = 0; c < 1030; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL refill cyc=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      if (fill_done) done_cnt++;
      tick();
      b_req = ($urandom_range(0, 1) == 1);
      b_addr = AW'($urandom);
      b_data = DW'($urandom);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL refill_done got=%0d exp=1", done_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_random();
    test_fill();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghost_ram_ctrl.md
GHOST_RAM_CTRL -- requirements
Module: ghost_ram_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 10, sprite RAM address bits (depth 2**ADDR_WIDTH).
REQ-002 Parameter: DATA_WIDTH, default 2, pixel color depth.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: a_req  input  1  requester A (host bus) write request.
REQ-006 Port: a_addr  input  ADDR_WIDTH  requester A write address.
REQ-007 Port: a_data  input  DATA_WIDTH  requester A write data.
REQ-008 Port: a_gnt  output  1  requester A grant (combinational).
REQ-009 Port: b_req  input  1  requester B (animation engine) write request.
REQ-010 Port: b_addr  input  ADDR_WIDTH  requester B write address.
REQ-011 Port: b_data  input  DATA_WIDTH  requester B write data.
REQ-012 Port: b_gnt  output  1  requester B grant (combinational).
REQ-013 Port: fill_start  input  1  single-cycle pulse; start whole-RAM fill.
REQ-014 Port: fill_color  input  DATA_WIDTH  fill value, sampled with fill_start.
REQ-015 Port: fill_busy  output  1  high while fill writes are issued.
REQ-016 Port: fill_done  output  1  one-cycle pulse at fill completion.
REQ-017 Port: ram_we  output  1  registered write enable to sprite RAM.
REQ-018 Port: ram_addr_w  output  ADDR_WIDTH  registered write address.
REQ-019 Port: ram_din  output  DATA_WIDTH  registered write data.

Function
REQ-020 Fill FSM states: IDLE, FILL, DONE.
REQ-021 IDLE + fill_start=1 -> FILL; fill counter cleared to 0; fill_color latched.
REQ-022 fill_start SHALL be ignored in FILL and DONE.
REQ-023 FILL: each cycle issue one write (counter, latched color); counter +1.
REQ-024 FILL with counter = 2**ADDR_WIDTH-1: issue last write, -> DONE; counter not wrapped to produce extra writes.
REQ-025 DONE: fill_done=1 for exactly one cycle, -> IDLE.
REQ-026 fill_busy = 1 exactly in FILL (2**ADDR_WIDTH cycles per fill).
REQ-027 In FILL, a_gnt=b_gnt=0 regardless of requests; fill has absolute priority.
REQ-028 Outside FILL: only one requester asserting req -> that requester granted same cycle.
REQ-029 Both requesting outside FILL: round-robin; grant the requester not granted last; last-grant pointer resets to B (A wins first contest).
REQ-030 Last-grant pointer updates only on a transfer (req & gnt at clock edge).
REQ-031 At most one grant high per cycle; gnt never high without corresponding req.
REQ-032 Requester holds req/addr/data stable until gnt seen; one write per granted cycle; continuous req with gnt yields back-to-back writes.
REQ-033 Transfer or fill write at edge N -> ram_we=1 with matching ram_addr_w/ram_din during cycle N+1 (latency 1).
REQ-034 No transfer at edge N -> ram_we=0 in cycle N+1; ram_addr_w/ram_din hold previous values.
REQ-035 fill_start in same cycle as a_req/b_req in IDLE: the requester's transfer completes that cycle; fill writes begin next cycle.
REQ-036 No read-port involvement; read path to RAM is untouched by this block.

Reset
REQ-037 reset_n=0 SHALL immediately force: state IDLE, counter 0, pointer B, ram_we=0, ram_addr_w=0, ram_din=0, fill_busy=0, fill_done=0.
REQ-038 Reset mid-fill SHALL abort without fill_done; partial RAM contents left as written.
REQ-039 Grants after reset follow REQ-028/029 on first active cycle.

Verification
REQ-040 Reset, a_req=1 a_addr=0x005 a_data=2'b11 one cycle -> a_gnt=1 that cycle; next cycle ram_we=1, ram_addr_w=0x005, ram_din=2'b11.
REQ-041 a_req and b_req held high 4 cycles -> grants A,B,A,B; ram_we high 4 consecutive cycles with matching addresses.
REQ-042 fill_start with fill_color=2'b01 -> fill_busy high 1024 cycles, ram_we high 1024 cycles addresses 0x000..0x3FF data 01, fill_done one pulse, then IDLE.
REQ-043 a_req high throughout fill -> a_gnt=0 for all 1024 FILL cycles; granted first cycle in DONE.
REQ-044 reset_n low at fill counter 0x200 -> ram_we, fill_busy drop immediately; no fill_done; new fill_start restarts at 0x000.
REQ-045 Second fill_start during FILL -> ignored; exactly 1024 writes, single fill_done.
